// File: rtl/spi_controller.sv
// spi_controller
//   SPI mode-0 initiator for 16-bit register frames sent MSB first:
//   {rw, addr[6:0], data[7:0]}.
//   Frame shape: SETUP, then 16 high phases with 15 low phases between them,
//   then HOLD and GAP. Each piece lasts CLK_DIV clk cycles.
//   Optional feature macro: SPI_CTRL_READ_EN.
//     Defined:   req_rw is sent as given. cipo is synchronised and captured
//                into rsp_data.
//     Undefined: every frame is a write, and rsp_valid/rsp_data stay at 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake, with req_rw, req_addr, req_data
//   busy                  frame in progress (ncs low, or inter-frame gap)
//   ncs, sclk, copi       SPI outputs (all registered)
//   cipo                  SPI input (read build only)
//   rsp_valid, rsp_data   read-data pulse and held read byte
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  input  logic       cipo,
  output logic       rsp_valid,
  output logic [7:0] rsp_data
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must lie in 2..255");
  end

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [14:0] shift_q, shift_d;   // bits still to be sent after the one on copi
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        phase_wrap;
  logic        accept;
  logic        rw_eff;

  assign phase_wrap = (phase_q == PH_LAST);
  assign accept     = (state_q == S_IDLE) && req_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    ready_d   = ready_q;
    busy_d    = busy_q;

    if (state_q != S_IDLE) begin
      phase_d = phase_wrap ? 8'd0 : phase_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        phase_d = 8'd0;
        if (accept) begin
          // The R/W bit goes straight onto copi, so it is valid the cycle ncs falls.
          copi_d    = rw_eff;
          shift_d   = {req_addr, req_data};
          ncs_d     = 1'b0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_wrap) begin
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (phase_wrap) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_cnt_q == 4'd15) begin
              state_d = S_HOLD;
            end else begin
              // copi only moves on the falling sclk edge, so it is stable at every rise.
              bit_cnt_d = bit_cnt_q + 4'd1;
              copi_d    = shift_q[14];
              shift_d   = {shift_q[13:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (phase_wrap) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_wrap) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 8'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 15'd0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign ncs       = ncs_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;

`ifdef SPI_CTRL_READ_EN
  logic       cipo_s1_q, cipo_s2_q;
  logic       rw_q, rw_d;
  logic [7:0] cap_q, cap_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       cap_en;
  logic       frame_end;

  assign rw_eff    = req_rw;
  // Sample at the end of each data-bit high phase; data bits are counts 8..15.
  assign cap_en    = (state_q == S_SHIFT) && sclk_q && phase_wrap && bit_cnt_q[3];
  assign frame_end = (state_q == S_HOLD) && phase_wrap;

  always_comb begin
    rw_d        = rw_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      rw_d = req_rw;
    end
    if (cap_en) begin
      cap_d = {cap_q[6:0], cipo_s2_q};
    end
    if (frame_end && !rw_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_s1_q   <= 1'b0;
      cipo_s2_q   <= 1'b0;
      rw_q        <= 1'b1;
      cap_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      cipo_s1_q   <= cipo;
      cipo_s2_q   <= cipo_s1_q;
      rw_q        <= rw_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  // Write-only build: the R/W bit is forced high and cipo is not observed.
  logic unused_read_inputs;
  assign unused_read_inputs = ^{req_rw, cipo};
  assign rw_eff    = 1'b1;
  assign rsp_valid = 1'b0;
  assign rsp_data  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller (CLK_DIV = 4). A frame-level model derives the
// expected ncs/sclk/copi/req_ready/busy/rsp values from the number of cycles
// elapsed since the accept edge. Directed tests then pin literal frame
// contents and timing.
module tb_spi_controller;
  localparam int D       = 4;
  localparam int NCS_LOW = 33 * D;
  localparam int FRAME   = 34 * D;
`ifdef SPI_CTRL_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b1;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       cipo = 1'b0;
  logic       req_ready, busy, ncs, sclk, copi, rsp_valid;
  logic [7:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .busy(busy),
    .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_frame = 16'd0;
  logic        m_rw = 1'b1;
  logic [7:0]  m_rsp = 8'd0;
  logic [7:0]  rd_byte = 8'hA5;   // byte the bench peripheral returns on cipo

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_rsp    = 8'd0;
    end else if ((!m_active || m_k >= FRAME) && req_valid) begin
      m_active = 1'b1;
      m_k      = 0;
      m_rw     = READ_EN ? req_rw : 1'b1;
      m_frame  = {m_rw, req_addr, req_data};
    end else if (m_active && m_k < FRAME) begin
      m_k++;
      if (READ_EN && m_k == NCS_LOW && !m_rw) m_rsp = rd_byte;
    end
  end

  // Bench peripheral: presents data bit (7 - (b-8)) during frame bits 8..15.
  always @(negedge clk) begin
    int b;
    cipo = 1'b0;
    if (m_active && m_k < NCS_LOW) begin
      b = m_k / (2 * D);
      if (b > 15) b = 15;
      if (b >= 8) cipo = rd_byte[15 - b];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_ncs, e_sclk, e_copi, e_rdy, e_rv;
    int b;
    e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; e_rdy = 1'b1; e_rv = 1'b0;
    if (rst_n && m_active && m_k < FRAME) begin
      e_rdy = 1'b0;
      if (m_k < NCS_LOW) begin
        e_ncs  = 1'b0;
        b      = m_k / (2 * D);
        if (b > 15) b = 15;
        e_copi = m_frame[15 - b];
        e_sclk = (m_k >= D) && (m_k < 32 * D) && (((m_k - D) % (2 * D)) < D);
      end
      e_rv = READ_EN && (m_k == NCS_LOW) && !m_rw;
    end
    chk("model_ncs", ncs, e_ncs);
    chk("model_sclk", sclk, e_sclk);
    chk("model_copi", copi, e_copi);
    chk("model_req_ready", req_ready, e_rdy);
    chk("model_busy", busy, !e_rdy);
    chk("model_rsp_valid", rsp_valid, e_rv);
    chk("model_rsp_data", rsp_data, m_rsp);
  end

  // ---------------- edge monitor ----------------
  int          cyc = 0;
  logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_rdy = 1'b1;
  logic [15:0] cap = 16'd0;
  int          rises = 0;
  int          rv_cnt = 0;
  logic [15:0] frames[$];
  int          fall_cyc[$], rise_cyc[$], rdy_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (p_ncs && !ncs) begin
      cap = 16'd0;
      rises = 0;
      fall_cyc.push_back(cyc);
    end
    if (!p_sclk && sclk) begin
      cap = {cap[14:0], copi};
      rises++;
      chk("copi_stable_at_sclk_rise", copi, p_copi);
      chk("sclk_only_while_ncs_low", ncs, 1'b0);
    end
    if (!p_ncs && ncs) begin
      frames.push_back(cap);
      rise_cyc.push_back(cyc);
    end
    if (!p_rdy && req_ready) rdy_cyc.push_back(cyc);
    if (rsp_valid) rv_cnt++;
    p_ncs = ncs; p_sclk = sclk; p_copi = copi; p_rdy = req_ready;
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_mon();
    frames.delete(); fall_cyc.delete(); rise_cyc.delete(); rdy_cyc.delete();
    rv_cnt = 0;
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); #1; n++; end
    chk("send_ready_timeout", req_ready, 1'b1);
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !busy) && n < 2000) begin @(negedge clk); #1; n++; end
    chk("idle_timeout", req_ready, 1'b1);
    @(negedge clk); #1;
  endtask

  task automatic pop_frame(input string name, input logic [15:0] exp);
    if (frames.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: no frame captured, expected %04h", name, exp);
    end else begin
      chk(name, frames.pop_front(), exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ncs", ncs, 1'b1);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_copi", copi, 1'b0);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Write 0x04 <- 0x80: frame 0x8480, ncs low 132 cycles, ready back 136 after accept.
    send(1'b1, 7'h04, 8'h80);
    wait_idle();
    pop_frame("t1_frame_bits", 16'h8480);
    chk("t1_ncs_low_cycles",
        (rise_cyc.size() > 0 && fall_cyc.size() > 0) ? rise_cyc[0] - fall_cyc[0] : -1, 132);
    chk("t1_ready_return_cycles",
        (rdy_cyc.size() > 0 && fall_cyc.size() > 0) ? rdy_cyc[0] - fall_cyc[0] : -1, 136);
    clear_mon();

    // Back-to-back with req_valid held. After ncs rises, GAP holds it high for
    // 4 cycles and IDLE adds the accept cycle, giving a 5-cycle gap and a
    // 137-cycle period.
    req_rw = 1'b1; req_addr = 7'h00; req_data = 8'hFF; req_valid = 1'b1;
    @(negedge clk); #1;
    req_addr = 7'h01; req_data = 8'h0F;
    begin
      int n = 0;
      while (!req_ready && n < 1000) begin @(negedge clk); #1; n++; end
      chk("b2b_ready_timeout", req_ready, 1'b1);
    end
    @(negedge clk); #1;
    req_valid = 1'b0;
    wait_idle();
    pop_frame("b2b_frame0", 16'h80FF);
    pop_frame("b2b_frame1", 16'h810F);
    chk("b2b_ncs_high_gap",
        (fall_cyc.size() > 1 && rise_cyc.size() > 0) ? fall_cyc[1] - rise_cyc[0] : -1, D + 1);
    chk("b2b_period",
        (fall_cyc.size() > 1) ? fall_cyc[1] - fall_cyc[0] : -1, FRAME + 1);
    clear_mon();

    // req_valid held while busy with changing data: only the accept-edge value is sent.
    req_rw = 1'b1; req_addr = 7'h02; req_data = 8'h11; req_valid = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      req_data = 8'h22 + 8'(i);
      @(negedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle();
    pop_frame("held_valid_frame", 16'h8211);
    clear_mon();

    // Another write pattern: addr 0x7F, data 0x55.
    send(1'b1, 7'h7F, 8'h55);
    wait_idle();
    pop_frame("t_ff55_frame", 16'hFF55);
    clear_mon();

    // Reset during bit 7 of a frame, then a clean frame.
    send(1'b1, 7'h05, 8'h3C);
    begin
      int n = 0;
      while (rises < 8 && n < 1000) begin @(negedge clk); #1; n++; end
      chk("mid_reset_reach_bit7", rises, 8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ncs_async", ncs, 1'b1);
    chk("mid_reset_sclk_async", sclk, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_ready", req_ready, 1'b1);
    clear_mon();
    send(1'b1, 7'h03, 8'h5A);
    wait_idle();
    pop_frame("post_reset_frame", 16'h835A);
    chk("post_reset_no_rsp", rv_cnt, 0);
    clear_mon();

    // Read request to address 0x02 while the bench peripheral returns 0xA5.
    send(1'b0, 7'h02, 8'h00);
    wait_idle();
    if (READ_EN) begin
      pop_frame("read_frame", 16'h0200);
      chk("read_rsp_pulses", rv_cnt, 1);
      chk("read_rsp_data", rsp_data, 8'hA5);
    end else begin
      pop_frame("read_forced_write_frame", 16'h8200);
      chk("read_rsp_pulses", rv_cnt, 0);
      chk("read_rsp_data", rsp_data, 8'h00);
    end
    clear_mon();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
